// File: rtl/fpu_pkg.sv
// Shared encodings, constants and the round/pack helper for the binary32 execute unit.
package fpu_pkg;

  localparam logic [5:0] OP_COP1   = 6'b010001;
  localparam logic [4:0] FMT_ARITH = 5'b10000;
  localparam logic [4:0] FMT_MFC1  = 5'b00000;
  localparam logic [4:0] FMT_MTC1  = 5'b00100;

  typedef enum logic [5:0] {
    FN_ADD = 6'b000000,
    FN_SUB = 6'b000001,
    FN_MUL = 6'b000010,
    FN_ABS = 6'b000101,
    FN_NEG = 6'b000111
  } funct_e;

  localparam int EXC_OVF = 0;
  localparam int EXC_UNF = 1;
  localparam int EXC_INV = 2;
  localparam int EXC_UNS = 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef struct packed {
    logic [3:0]  exc;
    logic [31:0] word;
  } fp_res_t;

  // Round-to-nearest-even on a normalised 24-bit significand (leading one at
  // bit 23), then pack with overflow-to-inf and flush-to-zero on underflow.
  function automatic fp_res_t fp_round_pack(input logic              s,
                                            input logic signed [10:0] e,
                                            input logic [23:0]        m,
                                            input logic               g,
                                            input logic               st);
    fp_res_t           r;
    logic [24:0]       mr;
    logic signed [10:0] er;
    r  = '0;
    mr = {1'b0, m} + {24'b0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = e + 11'sd1;
    end
    if (er >= 11'sd255) begin
      r.word         = s ? NINF : PINF;
      r.exc[EXC_OVF] = 1'b1;
    end else if (er <= 11'sd0) begin
      r.word         = {s, 31'b0};
      r.exc[EXC_UNF] = 1'b1;
    end else begin
      r.word = {s, er[7:0], mr[22:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_cmp.sv
// Combinational equality / greater-than compare of two binary32 words.
module fpu_cmp
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        feq,
  output logic        fgt
);

  logic               a_nan, b_nan, a_zero, b_zero;
  logic [30:0]        mag_a, mag_b;
  logic signed [31:0] key_a, key_b;

  // Map each operand to a signed key so a plain signed compare gives numeric
  // order; every exponent-0 value collapses to key 0 so -0 == +0.
  always_comb begin
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    mag_a  = a_zero ? 31'd0 : a[30:0];
    mag_b  = b_zero ? 31'd0 : b[30:0];
    key_a  = a[31] ? (32'sd0 - $signed({1'b0, mag_a})) : $signed({1'b0, mag_a});
    key_b  = b[31] ? (32'sd0 - $signed({1'b0, mag_b})) : $signed({1'b0, mag_b});
    feq    = !a_nan && !b_nan && ((a == b) || (a_zero && b_zero));
    fgt    = !a_nan && !b_nan && (key_a > key_b);
  end

endmodule

// File: rtl/fpu_unit.sv
// COP1 single-precision execute unit: add/sub/mul/abs/neg, moves and compares,
// all presented one cycle after the inputs.
module fpu_unit
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [4:0]  fmt,
  input  logic [5:0]  funct,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [3:0]  exception,
  output logic        feq,
  output logic        fgt
);

  fp32_t a, b;
  assign a = fs;
  assign b = ft;

  logic a_zero, b_zero, a_spec, b_spec;
  assign a_zero = (a.exp == 8'h00);
  assign b_zero = (b.exp == 8'h00);
  assign a_spec = (a.exp == 8'hFF);
  assign b_spec = (b.exp == 8'hFF);

  function automatic logic [5:0] lzc52(input logic [51:0] v);
    logic [5:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 51; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(51 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  fp_res_t            add_res;
  logic               bs_eff, swap, big_s, sm_s;
  logic [7:0]         big_e, sm_e, d;
  logic [4:0]         dc;
  logic [23:0]        big_m, sm_m;
  logic [50:0]        big_x, sm_x;
  logic [51:0]        sum, norm;
  logic [5:0]         lz;
  logic signed [10:0] e_add;

  // Add/sub: align the smaller magnitude with 27 spare bits so every shift that
  // can still matter is exact, then normalise and round once.
  always_comb begin
    add_res = '0;
    bs_eff  = b.sign ^ (funct == FN_SUB);
    swap    = 1'b0;
    big_s   = 1'b0;
    sm_s    = 1'b0;
    big_e   = '0;
    sm_e    = '0;
    big_m   = '0;
    sm_m    = '0;
    d       = '0;
    dc      = '0;
    big_x   = '0;
    sm_x    = '0;
    sum     = '0;
    norm    = '0;
    lz      = '0;
    e_add   = '0;
    if (a_spec || b_spec) begin
      add_res.word         = QNAN;
      add_res.exc[EXC_INV] = 1'b1;
    end else if (a_zero && b_zero) begin
      add_res.word = 32'h0000_0000;
    end else if (a_zero) begin
      add_res.word = {bs_eff, b.exp, b.man};
    end else if (b_zero) begin
      add_res.word = fs;
    end else begin
      swap  = {b.exp, b.man} > {a.exp, a.man};
      big_s = swap ? bs_eff : a.sign;
      sm_s  = swap ? a.sign : bs_eff;
      big_e = swap ? b.exp : a.exp;
      sm_e  = swap ? a.exp : b.exp;
      big_m = swap ? {1'b1, b.man} : {1'b1, a.man};
      sm_m  = swap ? {1'b1, a.man} : {1'b1, b.man};
      d     = big_e - sm_e;
      dc    = (d > 8'd27) ? 5'd27 : d[4:0];
      big_x = {big_m, 27'b0};
      sm_x  = {sm_m, 27'b0} >> dc;
      if (big_s == sm_s) sum = {1'b0, big_x} + {1'b0, sm_x};
      else               sum = {1'b0, big_x} - {1'b0, sm_x};
      if (sum == 52'd0) begin
        add_res.word = 32'h0000_0000;
      end else begin
        lz      = lzc52(sum);
        norm    = sum << lz;
        e_add   = $signed({3'b000, big_e}) + 11'sd1 - $signed({5'b00000, lz});
        add_res = fp_round_pack(big_s, e_add, norm[51:28], norm[27], |norm[26:0]);
      end
    end
  end

  fp_res_t            mul_res;
  logic               mul_s;
  logic [47:0]        prod;
  logic signed [10:0] e_mul;

  // Multiply: 24x24 significand product, one-bit normalise, shared rounding.
  always_comb begin
    mul_res = '0;
    mul_s   = a.sign ^ b.sign;
    prod    = '0;
    e_mul   = '0;
    if (a_spec || b_spec) begin
      mul_res.word         = QNAN;
      mul_res.exc[EXC_INV] = 1'b1;
    end else if (a_zero || b_zero) begin
      mul_res.word = {mul_s, 31'b0};
    end else begin
      prod  = 48'({1'b1, a.man}) * 48'({1'b1, b.man});
      e_mul = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - 11'sd127;
      if (prod[47])
        mul_res = fp_round_pack(mul_s, e_mul + 11'sd1, prod[47:24], prod[23], |prod[22:0]);
      else
        mul_res = fp_round_pack(mul_s, e_mul, prod[46:23], prod[22], |prod[21:0]);
    end
  end

  logic [31:0] nxt_result;
  logic [3:0]  nxt_exc;

  // Instruction decode selects which datapath result is registered.
  always_comb begin
    nxt_result = '0;
    nxt_exc    = '0;
    if (op == OP_COP1) begin
      if (fmt == FMT_ARITH) begin
        case (funct_e'(funct))
          FN_ADD, FN_SUB: begin
            nxt_result = add_res.word;
            nxt_exc    = add_res.exc;
          end
          FN_MUL: begin
            nxt_result = mul_res.word;
            nxt_exc    = mul_res.exc;
          end
          FN_ABS: nxt_result = {1'b0, fs[30:0]};
          FN_NEG: nxt_result = {~fs[31], fs[30:0]};
          default: nxt_exc[EXC_UNS] = 1'b1;
        endcase
      end else if (fmt == FMT_MFC1 || fmt == FMT_MTC1) begin
        nxt_result = ft;
      end
    end
  end

  logic cmp_eq, cmp_gt;

  fpu_cmp u_cmp (
    .a   (fs),
    .b   (ft),
    .feq (cmp_eq),
    .fgt (cmp_gt)
  );

  // Output register; reset takes priority over any issued op.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      result    <= '0;
      exception <= '0;
      feq       <= 1'b0;
      fgt       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      result    <= nxt_result;
      exception <= nxt_exc;
      feq       <= cmp_eq;
      fgt       <= cmp_gt;
    end
  end

endmodule

// File: tb/tb_fpu_unit.sv
// Directed-vector bench for fpu_unit with hand-computed expectations.
module tb_fpu_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [5:0]  op;
  logic [4:0]  fmt;
  logic [5:0]  funct;
  logic [31:0] fs, ft;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  exception;
  logic        feq, fgt;

  int vec_count = 0;
  int err_count = 0;

  localparam logic [5:0] COP1 = 6'b010001;
  localparam logic [4:0] ARITH = 5'b10000;

  always #5 clk = ~clk;

  fpu_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .op        (op),
    .fmt       (fmt),
    .funct     (funct),
    .fs        (fs),
    .ft        (ft),
    .out_valid (out_valid),
    .result    (result),
    .exception (exception),
    .feq       (feq),
    .fgt       (fgt)
  );

  typedef struct packed {
    logic [4:0]  fmt;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  x;
    logic        eq;
    logic        gt;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] f, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic [3:0] x,
                              input logic eq, input logic gt);
    vec_t v;
    v.fmt = f; v.fn = fn; v.a = a; v.b = b; v.r = r; v.x = x; v.eq = eq; v.gt = gt;
    return v;
  endfunction

  // Apply one set of inputs at the falling edge, let one rising edge pass, and
  // return 1 ns later so outputs are sampled away from the active edge.
  task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] f,
                       input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v; op = o; fmt = f; funct = fn; fs = a; ft = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    drive(1'b1, COP1, ARITH, 6'b000000, 32'h3F800000, 32'h3F800000);
    vec_count++;
    if ({out_valid, result, exception, feq, fgt} !== 39'd0) begin
      err_count++;
      $display("FAIL reset_state: got ov=%b r=%h x=%b eq=%b gt=%b, want all zero",
               out_valid, result, exception, feq, fgt);
    end
    rstn = 1'b1;
  endtask

  task automatic test_vectors(input string name, input logic [5:0] o, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      drive(1'b1, o, tbl[i].fmt, tbl[i].fn, tbl[i].a, tbl[i].b);
      vec_count++;
      if ({out_valid, result, exception, feq, fgt} !==
          {1'b1, tbl[i].r, tbl[i].x, tbl[i].eq, tbl[i].gt}) begin
        err_count++;
        $display("FAIL %s[%0d] fs=%h ft=%h: got ov=%b r=%h x=%b eq=%b gt=%b, want ov=1 r=%h x=%b eq=%b gt=%b",
                 name, i, tbl[i].a, tbl[i].b, out_valid, result, exception, feq, fgt,
                 tbl[i].r, tbl[i].x, tbl[i].eq, tbl[i].gt);
      end
    end
  endtask

  task automatic test_add;
    vec_t t[$];
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000, 1, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0000, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'b0000, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100, 0, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b0100, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0001, 1, 0));
    test_vectors("add", COP1, t);
  endtask

  task automatic test_sub_mul;
    vec_t t[$];
    t.push_back(mk(ARITH, 6'h01, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h01, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 0, 1));
    t.push_back(mk(ARITH, 6'h02, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h02, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0001, 0, 1));
    t.push_back(mk(ARITH, 6'h02, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0010, 0, 0));
    t.push_back(mk(ARITH, 6'h02, 32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h02, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b0100, 0, 0));
    t.push_back(mk(ARITH, 6'h02, 32'h00000005, 32'h40000000, 32'h00000000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h05, 32'hC0000000, 32'h00000000, 32'h40000000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h07, 32'h3F800000, 32'h3F800000, 32'hBF800000, 4'b0000, 1, 0));
    test_vectors("sub_mul", COP1, t);
  endtask

  task automatic test_compare;
    vec_t t[$];
    t.push_back(mk(ARITH, 6'h00, 32'h00000000, 32'h80000000, 32'h0, 4'b0, 1, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h40000000, 32'h3F800000, 32'h0, 4'b0, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'h7FC00000, 32'h3F800000, 32'h0, 4'b0, 0, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'h7FC00001, 32'h0, 4'b0, 0, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h7F800000, 32'h7F7FFFFF, 32'h0, 4'b0, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'hBF800000, 32'hC0000000, 32'h0, 4'b0, 0, 1));
    t.push_back(mk(ARITH, 6'h00, 32'hC0000000, 32'hBF800000, 32'h0, 4'b0, 0, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h00000001, 32'h80000000, 32'h0, 4'b0, 1, 0));
    t.push_back(mk(ARITH, 6'h00, 32'hFF800000, 32'hFF800000, 32'h0, 4'b0, 1, 0));
    t.push_back(mk(ARITH, 6'h00, 32'h80000000, 32'h3F800000, 32'h0, 4'b0, 0, 0));
    // op is not COP1 here, so only the compare flags are live
    test_vectors("compare", 6'b000000, t);
  endtask

  task automatic test_moves;
    vec_t t[$];
    t.push_back(mk(5'b00100, 6'h00, 32'h00000000, 32'h12345678, 32'h12345678, 4'b0000, 0, 0));
    t.push_back(mk(5'b00000, 6'h00, 32'h00000000, 32'h12345678, 32'h12345678, 4'b0000, 0, 0));
    t.push_back(mk(5'b00000, 6'h02, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b0000, 0, 0));
    t.push_back(mk(5'b00001, 6'h00, 32'h3F800000, 32'h40000000, 32'h00000000, 4'b0000, 0, 0));
    test_vectors("moves", COP1, t);
  endtask

  task automatic test_unsupported;
    vec_t t[$];
    t.push_back(mk(ARITH, 6'h03, 32'h3F800000, 32'h40000000, 32'h00000000, 4'b1000, 0, 0));
    t.push_back(mk(ARITH, 6'h3F, 32'h7FC00000, 32'h40000000, 32'h00000000, 4'b1000, 0, 0));
    test_vectors("unsupported", COP1, t);
  endtask

  task automatic test_valid_qualify;
    drive(1'b0, COP1, ARITH, 6'h00, 32'h3F800000, 32'h40000000);
    vec_count++;
    if ({out_valid, result, exception} !== {1'b0, 32'h40400000, 4'b0000}) begin
      err_count++;
      $display("FAIL valid_low: got ov=%b r=%h x=%b, want ov=0 r=40400000 x=0000",
               out_valid, result, exception);
    end
  endtask

  task automatic test_back_to_back;
    vec_t t[$];
    t.push_back(mk(ARITH, 6'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h02, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 0, 0));
    t.push_back(mk(ARITH, 6'h01, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 0, 0));
    t.push_back(mk(5'b00100, 6'h00, 32'h3F800000, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 0, 1));
    t.push_back(mk(ARITH, 6'h07, 32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000, 1, 0));
    test_vectors("back_to_back", COP1, t);
  endtask

  task automatic test_reset_midstream;
    rstn = 1'b0;
    drive(1'b1, COP1, ARITH, 6'h00, 32'h3F800000, 32'h40000000);
    vec_count++;
    if ({out_valid, result, exception, feq, fgt} !== 39'd0) begin
      err_count++;
      $display("FAIL reset_mid: got ov=%b r=%h x=%b eq=%b gt=%b, want all zero",
               out_valid, result, exception, feq, fgt);
    end
    rstn = 1'b1;
    drive(1'b1, COP1, ARITH, 6'h00, 32'h3F800000, 32'h40000000);
    vec_count++;
    if ({out_valid, result, exception, feq, fgt} !== {1'b1, 32'h40400000, 4'b0000, 1'b0, 1'b0}) begin
      err_count++;
      $display("FAIL reset_release: got ov=%b r=%h x=%b eq=%b gt=%b, want ov=1 r=40400000 x=0000 eq=0 gt=0",
               out_valid, result, exception, feq, fgt);
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; op = '0; fmt = '0; funct = '0; fs = '0; ft = '0;
    test_reset();
    test_add();
    test_sub_mul();
    test_compare();
    test_moves();
    test_unsupported();
    test_valid_qualify();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fpu_unit.md
Name: fpu_unit

Overview:
- Single-precision (IEEE-754 binary32) floating-point execute unit for the CPU's COP1 path.
- Covers FP arithmetic, FPR/GPR move pass-through, and the equality/greater-than comparisons used by fbne/fbg.
- Takes the raw instruction fields plus two operand values and returns one registered result, exception flags and compare flags one cycle later.

Parameters:
- None. Format is fixed at binary32.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  operands/fields valid this cycle
- op  in  6  instruction[31:26]; COP1 = 6'b010001
- fmt  in  5  instruction[25:21]; 10000 arith, 00000 mfc1, 00100 mtc1
- funct  in  6  instruction[5:0]
- fs  in  32  operand A (FPR fs)
- ft  in  32  operand B (FPR ft, or GPR rt for mtc1, selected by caller)
- out_valid  out  1  in_valid delayed 1 cycle
- result  out  32  result word
- exception  out  4  bit0 overflow, bit1 underflow, bit2 invalid/NaN-or-inf input, bit3 unsupported op
- feq  out  1  fs equals ft
- fgt  out  1  fs greater than ft

Behaviour:
- Reset: clk is the only clock; rstn is synchronous and active-low. On rstn=0 at a clk edge, out_valid, result, exception, feq and fgt all go to 0. Reset wins over any in_valid in the same cycle.
- Latency: fixed 1 cycle. A new op can be issued every cycle.
- Register update: all outputs load on every clk edge where rstn=1. The outputs depend only on that cycle's inputs; no internal state carries over.
- in_valid only qualifies out_valid. The datapath computes regardless of in_valid.
- Decode when op=COP1 and fmt=10000, selected by funct:
  - 000000 add: fs+ft
  - 000001 sub: fs-ft
  - 000010 mul: fs*ft
  - 000101 abs: fs with sign bit cleared
  - 000111 neg: fs with sign bit inverted
  - any other funct: result=0, exception bit3 set.
- fmt=00000 (mfc1) and fmt=00100 (mtc1): result=ft bit-exact, exception=0.
- op not COP1, or any other fmt: result=0, exception=0.
- Arithmetic rules:
  - Rounding is round-to-nearest-even.
  - Denormal inputs are treated as signed zero; denormal or underflowing results flush to signed zero and set bit1.
  - Exponent overflow gives ±inf (0x7F800000 / 0xFF800000) and sets bit1... no: sets bit0.
  - Any NaN or inf input to add/sub/mul gives result 0x7FC00000 and sets bit2.
  - Exact zero sum is +0 (0x00000000).
  - abs and neg never raise flags.
- Compare rules (computed for every op, independent of op/fmt/funct):
  - feq=1 if fs and ft are bitwise equal, or both are ±0 (any exponent-0 value counts as zero).
  - fgt=1 if fs > ft numerically: sign-magnitude order, -0 == +0.
  - If either operand is NaN (exp=FF, mantissa≠0): feq=0 and fgt=0.
  - inf compares by sign: +inf > any finite value.
- Simultaneous events: arithmetic, move and compare results all come from the same input cycle and are presented together.

Decomposition:
- Shared package fpu_pkg:
  - COP1 opcode; fmt codes ARITH/MFC1/MTC1
  - funct codes ADD/SUB/MUL/ABS/NEG
  - exception bit indices
  - canonical constants QNAN=0x7FC00000, PINF=0x7F800000, NINF=0xFF800000
- One sub-module, fpu_cmp: combinational, produces feq/fgt. Add/sub/mul live inline in fpu_unit.

Test Plan:
- Add: op=COP1, fmt=10000, funct=000000, fs=0x3F800000 (1.0), ft=0x40000000 (2.0) -> next cycle result=0x40400000 (3.0), exception=0, out_valid=1.
- Sub and mul: sub 1.0-2.0 -> 0xBF800000. mul 2.0*3.0 (0x40000000 * 0x40400000) -> 0x40C00000. mul 0x7F000000*0x40000000 -> 0x7F800000, exception bit0=1.
- Compare: fs=0x00000000, ft=0x80000000 -> feq=1, fgt=0. fs=0x40000000, ft=0x3F800000 -> feq=0, fgt=1. fs=0x7FC00000 with any ft -> feq=0, fgt=0.
- Moves: fmt=00100, ft=0x12345678 -> result=0x12345678, exception=0. Same for fmt=00000. Unsupported funct 000011 -> result=0, exception=4'b1000.
- Reset: hold a valid add active, assert rstn=0 for one edge -> all outputs 0 on that edge. Release rstn -> correct result one cycle after the next valid input.
